// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - MEM stage data RAM with memory-mapped TH/TL/TCON/LED/SYSTICK
// Optional timer block (TH/TL/TCON and Mem_IRQ) is built only when MEM_TIMER_EN is defined.
module mem_stage_dmem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] PERI_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Mem_ALUOut,
  input  logic [31:0] Mem_WrData,
  input  logic        Mem_MemRd,
  input  logic        Mem_MemWr,
  input  logic        Mem_Byte,
  input  logic        Mem_Signed,
  output logic [31:0] Mem_outB,
  output logic        Mem_IRQ,
  output logic [7:0]  led
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] ram_idx;
  logic [1:0]    lane;
  logic [4:0]    lane_lsb;
  logic          ram_sel;
  logic          peri_sel;
  logic [2:0]    peri_off;
  logic          led_wr;
  logic [31:0]   systick;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;

  // Word index ignores addr[1:0], so word accesses are always aligned
  assign ram_idx  = Mem_ALUOut[AW+1:2];
  assign lane     = Mem_ALUOut[1:0];
  assign lane_lsb = {lane, 3'b000};
  assign ram_sel  = (Mem_ALUOut[31:AW+2] == '0);
  assign peri_sel = (Mem_ALUOut[31:5] == PERI_BASE[31:5]);
  assign peri_off = Mem_ALUOut[4:2];
  assign led_wr   = Mem_MemWr && peri_sel && (peri_off == OFF_LED);

  // RAM store on the rising edge; a store issued while reset is held is dropped
  always_ff @(posedge clk) begin
    if (reset && Mem_MemWr && ram_sel) begin
      if (Mem_Byte) begin
        ram[ram_idx][lane_lsb +: 8] <= Mem_WrData[7:0];
      end else begin
        ram[ram_idx] <= Mem_WrData;
      end
    end
  end

  // LED register takes bits 7:0 for both byte and word stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= '0;
    end else if (led_wr) begin
      led <= Mem_WrData[7:0];
    end
  end

  // Free-running SYSTICK; CPU writes have no effect on it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
    end
  end

`ifdef MEM_TIMER_EN
  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] th_next;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;
  logic        peri_wr;
  logic        tl_wrap;
  logic        ovf_set;

  assign peri_wr = Mem_MemWr && peri_sel;
  assign tl_wrap = tcon[0] && (tl == 32'hFFFF_FFFF);
  assign ovf_set = tl_wrap && tcon[1];

  // Timer next state: count/reload first, then CPU writes override (TCON[2] set is sticky)
  always_comb begin
    th_next   = th;
    tl_next   = tl;
    tcon_next = tcon;
    if (tl_wrap) begin
      tl_next = th;
    end else if (tcon[0]) begin
      tl_next = tl + 32'd1;
    end
    if (ovf_set) begin
      tcon_next[2] = 1'b1;
    end
    if (peri_wr) begin
      case (peri_off)
        OFF_TH:   th_next   = Mem_Byte ? {th[31:8], Mem_WrData[7:0]} : Mem_WrData;
        OFF_TL:   tl_next   = Mem_Byte ? {tl[31:8], Mem_WrData[7:0]} : Mem_WrData;
        OFF_TCON: tcon_next = {Mem_WrData[2] | ovf_set, Mem_WrData[1:0]};
        default:  ;
      endcase
    end
  end

  // Timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      th   <= th_next;
      tl   <= tl_next;
      tcon <= tcon_next;
    end
  end

  assign Mem_IRQ = tcon[1] & tcon[2];
`else
  assign Mem_IRQ = 1'b0;
`endif

  // Combinational read mux; unmapped addresses read 0
  always_comb begin
    rd_word = '0;
    if (ram_sel) begin
      rd_word = ram[ram_idx];
    end else if (peri_sel) begin
      case (peri_off)
`ifdef MEM_TIMER_EN
        OFF_TH:      rd_word = th;
        OFF_TL:      rd_word = tl;
        OFF_TCON:    rd_word = {29'd0, tcon};
`endif
        OFF_LED:     rd_word = {24'd0, led};
        OFF_SYSTICK: rd_word = systick;
        default:     rd_word = '0;
      endcase
    end
  end

  // Peripherals expose only bits 7:0 to byte accesses regardless of lane
  assign rd_byte = ram_sel ? rd_word[lane_lsb +: 8] : rd_word[7:0];

  // Load data formatting; zero whenever no load is in the stage
  always_comb begin
    Mem_outB = '0;
    if (Mem_MemRd) begin
      if (Mem_Byte) begin
        Mem_outB = {{24{Mem_Signed & rd_byte[7]}}, rd_byte};
      end else begin
        Mem_outB = rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// tb/tb_mem_stage_dmem.sv - self-checking bench for mem_stage_dmem
module tb_mem_stage_dmem;
  localparam logic [31:0] PB = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Mem_ALUOut = '0;
  logic [31:0] Mem_WrData = '0;
  logic        Mem_MemRd = 1'b0;
  logic        Mem_MemWr = 1'b0;
  logic        Mem_Byte = 1'b0;
  logic        Mem_Signed = 1'b0;
  logic [31:0] Mem_outB;
  logic        Mem_IRQ;
  logic [7:0]  led;

  int total = 0;
  int bad = 0;

  mem_stage_dmem #(.DEPTH(256), .PERI_BASE(PB)) dut (
    .clk(clk), .reset(reset), .Mem_ALUOut(Mem_ALUOut), .Mem_WrData(Mem_WrData),
    .Mem_MemRd(Mem_MemRd), .Mem_MemWr(Mem_MemWr), .Mem_Byte(Mem_Byte),
    .Mem_Signed(Mem_Signed), .Mem_outB(Mem_outB), .Mem_IRQ(Mem_IRQ), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        byt;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_out;
    logic [7:0]  exp_led;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rd, input logic wr, input logic byt, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_out, input logic [7:0] exp_led);
    vec_t v;
    v.rd = rd; v.wr = wr; v.byt = byt; v.sgn = sgn;
    v.addr = addr; v.wdata = wdata; v.exp_out = exp_out; v.exp_led = exp_led;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One pipeline cycle: drive at negedge, outputs sampled 1 time unit later
  task automatic op(input logic rd, input logic wr, input logic byt, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    Mem_MemRd = rd; Mem_MemWr = wr; Mem_Byte = byt; Mem_Signed = sgn;
    Mem_ALUOut = addr; Mem_WrData = wdata;
    #1;
  endtask

  task automatic rdw(input logic [31:0] addr);
    op(1'b1, 1'b0, 1'b0, 1'b0, addr, 32'd0);
  endtask

  task automatic wrw(input logic [31:0] addr, input logic [31:0] data);
    op(1'b0, 1'b1, 1'b0, 1'b0, addr, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(0, 1, 0, 0, 32'h10,     32'hDEADBEEF, 32'h0,        8'h00);
    tbl[1]  = mk(1, 0, 0, 0, 32'h10,     32'h0,        32'hDEADBEEF, 8'h00);
    tbl[2]  = mk(1, 0, 0, 0, 32'h13,     32'h0,        32'hDEADBEEF, 8'h00);
    tbl[3]  = mk(0, 1, 0, 0, 32'h20,     32'h0,        32'h0,        8'h00);
    tbl[4]  = mk(0, 1, 1, 0, 32'h21,     32'h00000080, 32'h0,        8'h00);
    tbl[5]  = mk(1, 0, 0, 0, 32'h20,     32'h0,        32'h00008000, 8'h00);
    tbl[6]  = mk(1, 0, 1, 1, 32'h21,     32'h0,        32'hFFFFFF80, 8'h00);
    tbl[7]  = mk(1, 0, 1, 0, 32'h21,     32'h0,        32'h00000080, 8'h00);
    tbl[8]  = mk(1, 1, 0, 0, 32'h10,     32'h11223344, 32'hDEADBEEF, 8'h00);
    tbl[9]  = mk(1, 0, 0, 0, 32'h10,     32'h0,        32'h11223344, 8'h00);
    tbl[10] = mk(0, 1, 1, 0, 32'h13,     32'h0000007F, 32'h0,        8'h00);
    tbl[11] = mk(1, 0, 0, 0, 32'h10,     32'h0,        32'h7F223344, 8'h00);
    tbl[12] = mk(1, 0, 1, 1, 32'h13,     32'h0,        32'h0000007F, 8'h00);
    tbl[13] = mk(1, 0, 1, 0, 32'h12,     32'h0,        32'h00000022, 8'h00);
    tbl[14] = mk(0, 1, 0, 0, PB + 32'hC, 32'h123456A5, 32'h0,        8'h00);
    tbl[15] = mk(1, 0, 0, 0, PB + 32'hC, 32'h0,        32'h000000A5, 8'hA5);
    tbl[16] = mk(1, 0, 1, 1, PB + 32'hD, 32'h0,        32'hFFFFFFA5, 8'hA5);
    tbl[17] = mk(0, 1, 0, 0, PB + 32'h20, 32'hFFFFFFFF, 32'h0,       8'hA5);
    tbl[18] = mk(1, 0, 0, 0, PB + 32'h20, 32'h0,       32'h0,        8'hA5);
    tbl[19] = mk(0, 1, 0, 0, PB + 32'h10, 32'hFFFFFFFF, 32'h0,       8'hA5);
    tbl[20] = mk(1, 0, 0, 0, PB + 32'h10, 32'h0,       32'h0,        8'hA5);
    tbl[21] = mk(1, 0, 0, 0, 32'h20,     32'h0,        32'h00008000, 8'hA5);
    tbl[22] = mk(1, 0, 0, 0, PB + 32'hC, 32'h0,        32'h000000A5, 8'hA5);
    tbl[23] = mk(0, 1, 1, 0, PB + 32'hE, 32'h0000005A, 32'h0,        8'hA5);
    tbl[24] = mk(1, 0, 1, 0, PB + 32'hC, 32'h0,        32'h0000005A, 8'h5A);
    tbl[25] = mk(0, 1, 0, 0, PB + 32'hC, 32'h000000A5, 32'h0,        8'h5A);
    tbl[26] = mk(1, 0, 0, 0, PB + 32'hC, 32'h0,        32'h000000A5, 8'hA5);
    tbl[27] = mk(0, 0, 0, 0, 32'h10,     32'h0,        32'h0,        8'hA5);

    // Reset state and SYSTICK counting from release
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rdw(PB + 32'h14);
    check("systick_first", Mem_outB, 32'd1);
    check("reset_led", {24'd0, led}, 32'h0);
    check("reset_irq", {31'd0, Mem_IRQ}, 32'h0);
    rdw(PB + 32'h8);
    check("reset_tcon", Mem_outB, 32'h0);
    rdw(PB + 32'h14);
    check("systick_third", Mem_outB, 32'd3);

    // Table of RAM / LED / unmapped vectors
    for (int i = 0; i < NV; i++) begin
      op(tbl[i].rd, tbl[i].wr, tbl[i].byt, tbl[i].sgn, tbl[i].addr, tbl[i].wdata);
      check($sformatf("vec%0d_out", i), Mem_outB, tbl[i].exp_out);
      check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, tbl[i].exp_led});
    end

`ifdef MEM_TIMER_EN
    // Overflow reload and sticky flag
    wrw(PB + 32'h0, 32'hFFFF_FFF0);
    wrw(PB + 32'h4, 32'hFFFF_FFFE);
    wrw(PB + 32'h8, 32'h3);
    rdw(PB + 32'h4);
    check("t3_tl0", Mem_outB, 32'hFFFF_FFFE);
    check("t3_irq0", {31'd0, Mem_IRQ}, 32'h0);
    rdw(PB + 32'h4);
    check("t3_tl1", Mem_outB, 32'hFFFF_FFFF);
    rdw(PB + 32'h4);
    check("t3_reload", Mem_outB, 32'hFFFF_FFF0);
    check("t3_irq1", {31'd0, Mem_IRQ}, 32'h1);
    rdw(PB + 32'h8);
    check("t3_tcon7", Mem_outB, 32'h7);
    wrw(PB + 32'h8, 32'h3);
    check("t3_irq_held", {31'd0, Mem_IRQ}, 32'h1);
    rdw(PB + 32'h8);
    check("t3_tcon3", Mem_outB, 32'h3);
    check("t3_irq_drop", {31'd0, Mem_IRQ}, 32'h0);

    // Clear of TCON[2] in the overflow cycle loses to the overflow set
    wrw(PB + 32'h8, 32'h0);
    wrw(PB + 32'h4, 32'hFFFF_FFFF);
    wrw(PB + 32'h8, 32'h3);
    wrw(PB + 32'h8, 32'h3);
    check("t4_irq_pre", {31'd0, Mem_IRQ}, 32'h0);
    rdw(PB + 32'h8);
    check("t4_tcon_sticky", Mem_outB, 32'h7);
    check("t4_irq", {31'd0, Mem_IRQ}, 32'h1);
    rdw(PB + 32'h4);
    check("t4_tl_after", Mem_outB, 32'hFFFF_FFF1);
    // CPU write to TL in the overflow cycle beats the reload
    wrw(PB + 32'h8, 32'h0);
    wrw(PB + 32'h4, 32'hFFFF_FFFF);
    wrw(PB + 32'h8, 32'h3);
    wrw(PB + 32'h4, 32'h5);
    rdw(PB + 32'h4);
    check("t4_tl_write_wins", Mem_outB, 32'h5);
    check("t4_irq2", {31'd0, Mem_IRQ}, 32'h1);
`else
    // Timer not built: its registers read 0 and never interrupt
    wrw(PB + 32'h0, 32'hFFFF_FFF0);
    wrw(PB + 32'h4, 32'hFFFF_FFFE);
    wrw(PB + 32'h8, 32'h3);
    for (int i = 0; i < 4; i++) begin
      rdw(PB + 32'h4);
      check($sformatf("t6_tl%0d", i), Mem_outB, 32'h0);
      check($sformatf("t6_irq%0d", i), {31'd0, Mem_IRQ}, 32'h0);
    end
    rdw(PB + 32'h0);
    check("t6_th", Mem_outB, 32'h0);
    rdw(PB + 32'h8);
    check("t6_tcon", Mem_outB, 32'h0);
    wrw(PB + 32'hC, 32'h0000003C);
    rdw(PB + 32'hC);
    check("t6_led", {24'd0, led}, 32'h3C);
    wrw(PB + 32'hC, 32'h000000A5);
`endif

    // Asynchronous reset in the middle of an LED store
    op(1'b0, 1'b1, 1'b0, 1'b0, PB + 32'hC, 32'h0000005A);
    check("rst_led_pre", {24'd0, led}, 32'hA5);
    #1 reset = 1'b0;
    #1;
    check("rst_led_async", {24'd0, led}, 32'h0);
    check("rst_irq_async", {31'd0, Mem_IRQ}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_store_lost", {24'd0, led}, 32'h0);
    Mem_MemWr = 1'b0;
    Mem_MemRd = 1'b1;
    Mem_ALUOut = PB + 32'h14;
    #1;
    check("rst_systick", Mem_outB, 32'h0);
    Mem_ALUOut = PB + 32'h8;
    #1;
    check("rst_tcon", Mem_outB, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rdw(PB + 32'hC);
    check("post_rst_led", Mem_outB, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
